// File: rtl/truth_table_sweep_pkg.sv
// Shared constants for the truth-table sweeper: state encoding and default sizing.
package truth_table_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int N_IN_DEFAULT    = 3;
    localparam int TABLE_W_DEFAULT = 2 ** N_IN_DEFAULT;

endpackage

// File: rtl/truth_table_sweep_settle_timer.sv
// Loadable down-counter that times how long each stimulus vector is held before sampling.
module settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    // A load always wins so a new vector can start in the same cycle the timer is cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweep.sv
// Sweeps every input combination of a small boolean function and captures its truth table.
// Define TRUTH_TABLE_COMPARE_EN to build the comparator against EXPECTED that drives mismatch.
module truth_table_sweep
    import truth_table_sweep_pkg::*;
#(
    parameter int                  N_IN     = N_IN_DEFAULT,
    parameter int                  SETTLE   = 1,
    parameter logic [2**N_IN-1:0]  EXPECTED = 8'b0100_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [N_IN-1:0]      stim,
    input  logic                 resp,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_o,
    output logic                 mismatch
);

    localparam int TABLE_W = 2 ** N_IN;
    localparam int CW      = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);

    state_e              state_q;
    logic [N_IN-1:0]     idx_q;
    logic                busy_q;
    logic                done_q;
    logic [TABLE_W-1:0]  table_q;
    logic [TABLE_W-1:0]  table_d;
    logic                lastIdx;
    logic                timerLoad;
    logic                timerClear;
    logic                timerExpired;

    assign lastIdx    = (idx_q == {N_IN{1'b1}});
    assign timerLoad  = (((state_q == IDLE) || (state_q == DONE)) && start)
                      || ((state_q == SAMPLE) && !lastIdx);
    assign timerClear = (state_q == IDLE);

    settle_timer #(.W(CW)) u_settle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (timerClear),
        .load_i     (timerLoad),
        .load_val_i (LOAD_VAL),
        .en_i       (state_q == DRIVE),
        .expired_o  (timerExpired)
    );

    always_comb begin
        table_d        = table_q;
        table_d[idx_q] = resp;
    end

`ifdef TRUTH_TABLE_COMPARE_EN
    logic mismatch_q;
`else
    localparam logic unused_expected = ^EXPECTED;
`endif

    // The DONE branch shares the IDLE start handling so a held start restarts immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            table_q    <= '0;
`ifdef TRUTH_TABLE_COMPARE_EN
            mismatch_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q    <= DRIVE;
                        idx_q      <= '0;
                        busy_q     <= 1'b1;
                        table_q    <= '0;
`ifdef TRUTH_TABLE_COMPARE_EN
                        mismatch_q <= 1'b0;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DRIVE: begin
                    if (timerExpired) begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    table_q <= table_d;
                    if (lastIdx) begin
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
`ifdef TRUTH_TABLE_COMPARE_EN
                        mismatch_q <= (table_d != EXPECTED);
`endif
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= DRIVE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stim    = idx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign table_o = table_q;
`ifdef TRUTH_TABLE_COMPARE_EN
    assign mismatch = mismatch_q;
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_sweep.sv
// Directed testbench for truth_table_sweep: one DUT with SETTLE=1 and one with SETTLE=3.
module tb_truth_table_sweep;
    import truth_table_sweep_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                        rst_n;
    logic                        startA, startB;
    logic                        respMode;
    logic [N_IN_DEFAULT-1:0]     stimA, stimB;
    logic                        respA, respB;
    logic                        busyA, busyB, doneA, doneB;
    logic [TABLE_W_DEFAULT-1:0]  tableA, tableB;
    logic                        mismatchA, mismatchB;

    int testsRun    = 0;
    int testsFailed = 0;

`ifdef TRUTH_TABLE_COMPARE_EN
    localparam logic STUCK_MM = 1'b1;
`else
    localparam logic STUCK_MM = 1'b0;
`endif

    // Function under test is s = x & y & ~z, or stuck at 1 when respMode is set.
    assign respA = respMode ? 1'b1 : (stimA == 3'b110);
    assign respB = (stimB == 3'b110);

    truth_table_sweep #(.N_IN(3), .SETTLE(1), .EXPECTED(8'b0100_0000)) dutA (
        .clk(clk), .rst_n(rst_n), .start(startA), .stim(stimA), .resp(respA),
        .busy(busyA), .done(doneA), .table_o(tableA), .mismatch(mismatchA)
    );

    truth_table_sweep #(.N_IN(3), .SETTLE(3), .EXPECTED(8'b0100_0000)) dutB (
        .clk(clk), .rst_n(rst_n), .start(startB), .stim(stimB), .resp(respB),
        .busy(busyB), .done(doneB), .table_o(tableB), .mismatch(mismatchB)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        startA = 1'b1;
        startB = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            testsRun++;
            if ({stimA, busyA, doneA, tableA, mismatchA} !== 13'd0) begin
                testsFailed++;
                $display("[TB] FAIL reset_A cycle %0d got stim=%0d busy=%b done=%b table=%h mm=%b want all 0",
                         c, stimA, busyA, doneA, tableA, mismatchA);
            end
            testsRun++;
            if ({stimB, busyB, doneB, tableB, mismatchB} !== 13'd0) begin
                testsFailed++;
                $display("[TB] FAIL reset_B cycle %0d got stim=%0d busy=%b done=%b table=%h mm=%b want all 0",
                         c, stimB, busyB, doneB, tableB, mismatchB);
            end
        end
        startA = 1'b0;
        startB = 1'b0;
        rst_n  = 1'b1;
        tick();
        testsRun++;
        if (busyA !== 1'b0 || stimA !== 3'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_release got busy=%b stim=%0d want busy=0 stim=0", busyA, stimA);
        end
    endtask

    task automatic test_nominal();
        logic [2:0] expStim;
        respMode = 1'b0;
        startA   = 1'b1;
        tick();
        startA = 1'b0;
        for (int n = 1; n <= 18; n++) begin
            if (n > 1) tick();
            expStim = (n <= 16) ? 3'((n - 1) / 2) : 3'd7;
            testsRun++;
            if (stimA !== expStim) begin
                testsFailed++;
                $display("[TB] FAIL nominal_stim t0+%0d got %0d want %0d", n, stimA, expStim);
            end
            testsRun++;
            if (busyA !== (n <= 16) || doneA !== (n == 17)) begin
                testsFailed++;
                $display("[TB] FAIL nominal_busy_done t0+%0d got busy=%b done=%b want busy=%b done=%b",
                         n, busyA, doneA, (n <= 16), (n == 17));
            end
            if (n >= 17) begin
                testsRun++;
                if (tableA !== 8'b0100_0000 || mismatchA !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL nominal_table t0+%0d got table=%b mm=%b want 01000000 mm=0",
                             n, tableA, mismatchA);
                end
            end
        end
    endtask

    task automatic test_stuck();
        respMode = 1'b1;
        startA   = 1'b1;
        tick();
        startA = 1'b0;
        for (int n = 2; n <= 18; n++) begin
            tick();
            if (n >= 17) begin
                testsRun++;
                if (tableA !== 8'hFF || mismatchA !== STUCK_MM || doneA !== (n == 17)) begin
                    testsFailed++;
                    $display("[TB] FAIL stuck t0+%0d got table=%h mm=%b done=%b want table=ff mm=%b done=%b",
                             n, tableA, mismatchA, doneA, STUCK_MM, (n == 17));
                end
            end
        end
        respMode = 1'b0;
    endtask

    task automatic test_start_while_busy();
        bit seen;
        startA = 1'b1;
        tick();
        for (int n = 1; n <= 18; n++) begin
            if (n > 1) tick();
            testsRun++;
            if (doneA !== (n == 17)) begin
                testsFailed++;
                $display("[TB] FAIL busy_start_done t0+%0d got %b want %b", n, doneA, (n == 17));
            end
            if (n == 17) begin
                testsRun++;
                if (tableA !== 8'b0100_0000) begin
                    testsFailed++;
                    $display("[TB] FAIL busy_start_table got %b want 01000000", tableA);
                end
            end
        end
        testsRun++;
        if (stimA !== 3'd0 || busyA !== 1'b1 || tableA !== 8'h00 || mismatchA !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL busy_start_restart got stim=%0d busy=%b table=%h mm=%b want 0 1 00 0",
                     stimA, busyA, tableA, mismatchA);
        end
        startA = 1'b0;
        seen   = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            if (doneA) seen = 1'b1;
        end
        testsRun++;
        if (!seen) begin
            testsFailed++;
            $display("[TB] FAIL busy_start_drain got no done want done within 40 cycles");
        end
        tick();
    endtask

    task automatic test_reset_mid();
        respMode = 1'b1;
        startA   = 1'b1;
        tick();
        startA = 1'b0;
        for (int n = 2; n <= 9; n++) tick();
        testsRun++;
        if (tableA !== 8'h0F || busyA !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL midreset_partial got table=%h busy=%b want 0f 1", tableA, busyA);
        end
        rst_n = 1'b0;
        #1;
        testsRun++;
        if ({stimA, busyA, doneA, tableA, mismatchA} !== 13'd0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_async got stim=%0d busy=%b done=%b table=%h mm=%b want all 0",
                     stimA, busyA, doneA, tableA, mismatchA);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            testsRun++;
            if (doneA !== 1'b0 || busyA !== 1'b0 || tableA !== 8'h00) begin
                testsFailed++;
                $display("[TB] FAIL midreset_idle cycle %0d got done=%b busy=%b table=%h want 0 0 00",
                         c, doneA, busyA, tableA);
            end
        end
        respMode = 1'b0;
    endtask

    task automatic test_long_settle();
        logic [2:0] expStim;
        startB = 1'b1;
        tick();
        startB = 1'b0;
        for (int n = 1; n <= 34; n++) begin
            if (n > 1) tick();
            expStim = (n <= 32) ? 3'((n - 1) / 4) : 3'd7;
            testsRun++;
            if (stimB !== expStim) begin
                testsFailed++;
                $display("[TB] FAIL long_stim t0+%0d got %0d want %0d", n, stimB, expStim);
            end
            testsRun++;
            if (busyB !== (n <= 32) || doneB !== (n == 33)) begin
                testsFailed++;
                $display("[TB] FAIL long_busy_done t0+%0d got busy=%b done=%b want busy=%b done=%b",
                         n, busyB, doneB, (n <= 32), (n == 33));
            end
        end
        testsRun++;
        if (tableB !== 8'b0100_0000 || mismatchB !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL long_table got table=%b mm=%b want 01000000 0", tableB, mismatchB);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        startA   = 1'b0;
        startB   = 1'b0;
        respMode = 1'b0;
        test_reset();
        test_nominal();
        test_stuck();
        test_start_while_busy();
        test_reset_mid();
        test_long_settle();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
